mixed_rr_scheduler: RTL

Round-robin scheduler that shares one registered-AND evaluation stage among `N_REQ` single-bit requesters. Each grant combines the granted requester's current data bit with that requester's previously accepted bit. The result is registered. The block sits in front of the mixed combinational/flip-flop test datapaths as a richer fault-injection target: pointer flops, history flops, output flops and a combinational priority search.

---
 rtl/mixed_rr_scheduler.sv | 100 ++++++++++
 1 files changed

// File: rtl/mixed_rr_scheduler.sv
// mixed_rr_scheduler: round-robin scheduler that shares one registered AND
// stage among N_REQ single-bit requesters. Each grant ANDs the requester's
// current data bit with its previously accepted bit and registers the result.
//
// Ports:
//   clk          in   clock, rising-edge
//   rst          in   asynchronous active-high reset
//   en           in   scheduler enable; no grants while low
//   clear        in   synchronous clear of all history bits
//   req          in   per-requester request (N_REQ)
//   data         in   per-requester data bit (N_REQ)
//   gnt          out  one-hot combinational grant (N_REQ)
//   result       out  registered data[k] & hist[k] of the last grant
//   result_valid out  one-cycle pulse the cycle after a grant
//   result_id    out  index of the grant that produced result (ID_W)
module mixed_rr_scheduler #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  data,
    output logic [N_REQ-1:0]  gnt,
    output logic              result,
    output logic              result_valid,
    output logic [ID_W-1:0]   result_id
);

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

    logic [ID_W-1:0]  ptr;
    logic [N_REQ-1:0] hist;
    logic             grant_any;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  next_ptr;

    // Priority search starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        int unsigned cand;
        gnt       = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        if (en) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                cand = 32'(ptr) + i;
                if (cand >= N_REQ) begin
                    cand = cand - N_REQ;
                end
                if (!grant_any && req[ID_W'(cand)]) begin
                    grant_any = 1'b1;
                    grant_idx = ID_W'(cand);
                end
            end
        end
        if (grant_any) begin
            gnt[grant_idx] = 1'b1;
        end
    end

    // Explicit wrap so non-power-of-two N_REQ returns to 0.
    always_comb begin
        next_ptr = '0;
        if (grant_idx != LAST_IDX) begin
            next_ptr = grant_idx + ID_W'(1);
        end
    end

    // Pointer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            result       <= 1'b0;
            result_valid <= 1'b0;
            result_id    <= '0;
        end else begin
            result_valid <= grant_any;
            if (grant_any) begin
                ptr       <= next_ptr;
                result    <= data[grant_idx] & hist[grant_idx];
                result_id <= grant_idx;
            end
        end
    end

    // History bits; clear wins over a same-cycle grant update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
        end else if (clear) begin
            hist <= '0;
        end else if (grant_any) begin
            hist[grant_idx] <= data[grant_idx];
        end
    end

endmodule
